scanner_unit: RTL and testbench

SCANNER_UNIT -- requirements
Module: scanner_unit

---
 rtl/scanner_pkg.sv | 16 +
 rtl/seg7.sv | 26 ++
 rtl/scanner_unit.sv | 95 +++++++++
 tb/tb_scanner_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/scanner_pkg.sv
// Shared types and constants for the scanner unit.
package scanner_pkg;

  typedef enum logic [2:0] {
    LOW_POWER    = 3'd0,
    STANDBY      = 3'd1,
    SCANNING     = 3'd2,
    IDLE         = 3'd3,
    TRANSFERRING = 3'd4,
    FLUSHING     = 3'd5
  } state_t;

  localparam logic [3:0] COUNT_FULL = 4'd10;
  localparam logic [3:0] WAKE_AT    = 4'd8;

endpackage

// File: rtl/seg7.sv
// Active-low seven-segment decoder, segment order gfedcba.
// Values 10..15 all show "F" (buffer full marker).
module seg7 (
  input  logic [3:0] value,
  output logic [6:0] seg
);

  // Pure combinational digit lookup
  always_comb begin
    seg = 7'b0001110;
    case (value)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/scanner_unit.sv
// Scanner unit: fills a buffer while SCANNING, then drains it by transfer
// or discards it by flush. Two units hand the scanning role back and forth
// through wake_out/start_out -> peer wake_in/start_in.
module scanner_unit
  import scanner_pkg::*;
#(
  parameter int INIT_ACTIVE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wake_in,
  input  logic       start_in,
  input  logic       xfer_ok,
  input  logic       flush,
  output logic       wake_out,
  output logic       start_out,
  output logic [2:0] state,
  output logic [3:0] count,
  output logic [6:0] hex_state,
  output logic [6:0] hex_count
);

  state_t st;

  assign state = st;

  // Main FSM: state, buffer count and the registered peer pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= (INIT_ACTIVE != 0) ? SCANNING : LOW_POWER;
      count     <= 4'd0;
      wake_out  <= 1'b0;
      start_out <= 1'b0;
    end else begin
      // pulses default low so each lasts a single cycle
      wake_out  <= 1'b0;
      start_out <= 1'b0;
      case (st)
        LOW_POWER: begin
          count <= 4'd0;
          if (wake_in) st <= STANDBY;
        end
        STANDBY: begin
          count <= 4'd0;
          if (start_in) st <= SCANNING;
        end
        SCANNING: begin
          if (count < COUNT_FULL) begin
            count <= count + 4'd1;
            // pulses line up with the cycle the new count becomes visible
            if (count + 4'd1 == WAKE_AT) wake_out <= 1'b1;
            if (count + 4'd1 == COUNT_FULL) begin
              start_out <= 1'b1;
              st        <= IDLE;
            end
          end else begin
            st <= IDLE;
          end
        end
        IDLE: begin
          count <= COUNT_FULL;
          if (flush)        st <= FLUSHING;
          else if (xfer_ok) st <= TRANSFERRING;
        end
        TRANSFERRING: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
            if (count == 4'd1) st <= LOW_POWER;
          end else begin
            st <= LOW_POWER;
          end
        end
        FLUSHING: begin
          count <= 4'd0;
          st    <= LOW_POWER;
        end
        default: begin
          count <= 4'd0;
          st    <= LOW_POWER;
        end
      endcase
    end
  end

  seg7 u_seg_state (
    .value ({1'b0, state}),
    .seg   (hex_state)
  );

  seg7 u_seg_count (
    .value (count),
    .seg   (hex_count)
  );

endmodule

// File: tb/tb_scanner_unit.sv
// Directed bench for scanner_unit: an INIT_ACTIVE=1 unit, an INIT_ACTIVE=0
// unit and a cross-coupled pair.
module tb_scanner_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;

  // Active unit (INIT_ACTIVE=1)
  logic       r1 = 1'b1, wi1 = 1'b0, si1 = 1'b0, x1 = 1'b0, f1 = 1'b0;
  logic       wo1, so1;
  logic [2:0] st1;
  logic [3:0] c1;
  logic [6:0] hs1, hc1;

  // Low-power unit (INIT_ACTIVE=0)
  logic       r0 = 1'b1, wi0 = 1'b0, si0 = 1'b0, x0 = 1'b0, f0 = 1'b0;
  logic       wo0, so0;
  logic [2:0] st0;
  logic [3:0] c0;
  logic [6:0] hs0, hc0;

  // Cross-coupled pair
  logic       rp = 1'b1;
  logic       wa, sa, wb, sb;
  logic [2:0] sta, stb;
  logic [3:0] ca, cb;
  logic [6:0] hsa, hca, hsb, hcb;

  scanner_unit #(.INIT_ACTIVE(1)) u_act (
    .clk(clk), .reset(r1), .wake_in(wi1), .start_in(si1), .xfer_ok(x1), .flush(f1),
    .wake_out(wo1), .start_out(so1), .state(st1), .count(c1),
    .hex_state(hs1), .hex_count(hc1));

  scanner_unit #(.INIT_ACTIVE(0)) u_low (
    .clk(clk), .reset(r0), .wake_in(wi0), .start_in(si0), .xfer_ok(x0), .flush(f0),
    .wake_out(wo0), .start_out(so0), .state(st0), .count(c0),
    .hex_state(hs0), .hex_count(hc0));

  scanner_unit #(.INIT_ACTIVE(1)) u_pa (
    .clk(clk), .reset(rp), .wake_in(wb), .start_in(sb), .xfer_ok(1'b1), .flush(1'b0),
    .wake_out(wa), .start_out(sa), .state(sta), .count(ca),
    .hex_state(hsa), .hex_count(hca));

  scanner_unit #(.INIT_ACTIVE(0)) u_pb (
    .clk(clk), .reset(rp), .wake_in(wa), .start_in(sa), .xfer_ok(1'b1), .flush(1'b0),
    .wake_out(wb), .start_out(sb), .state(stb), .count(cb),
    .hex_state(hsb), .hex_count(hcb));

  // Hand-written digit table, gfedcba active low
  logic [6:0] seg_tbl [0:10];
  initial begin
    seg_tbl[0]  = 7'b1000000; seg_tbl[1] = 7'b1111001; seg_tbl[2] = 7'b0100100;
    seg_tbl[3]  = 7'b0110000; seg_tbl[4] = 7'b0011001; seg_tbl[5] = 7'b0010010;
    seg_tbl[6]  = 7'b0000010; seg_tbl[7] = 7'b1111000; seg_tbl[8] = 7'b0000000;
    seg_tbl[9]  = 7'b0010000; seg_tbl[10] = 7'b0001110;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    r1 = 1'b0; r0 = 1'b0; rp = 1'b0;
    nvec++; if (st1 !== 3'd2) begin nbad++; $display("FAIL reset_state_act got %0d want 2", st1); end
    nvec++; if (c1 !== 4'd0) begin nbad++; $display("FAIL reset_count_act got %0d want 0", c1); end
    nvec++; if (wo1 !== 1'b0 || so1 !== 1'b0) begin nbad++; $display("FAIL reset_pulses_act got %b%b want 00", wo1, so1); end
    nvec++; if (hs1 !== 7'b0100100) begin nbad++; $display("FAIL reset_hex_state_act got %b want 0100100", hs1); end
    nvec++; if (st0 !== 3'd0) begin nbad++; $display("FAIL reset_state_low got %0d want 0", st0); end
    nvec++; if (hs0 !== 7'b1000000) begin nbad++; $display("FAIL reset_hex_state_low got %b want 1000000", hs0); end
    nvec++; if (hc0 !== 7'b1000000) begin nbad++; $display("FAIL reset_hex_count_low got %b want 1000000", hc0); end
  endtask

  // Fill from 0 to 10 with xfer_ok high
  task automatic test_scan();
    x1 = 1'b1; f1 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      nvec++; if (c1 !== 4'(c)) begin nbad++; $display("FAIL scan_count cyc %0d got %0d want %0d", c, c1, c); end
      nvec++; if (wo1 !== (c == 8)) begin nbad++; $display("FAIL scan_wake cyc %0d got %b want %b", c, wo1, c == 8); end
      nvec++; if (so1 !== (c == 10)) begin nbad++; $display("FAIL scan_start cyc %0d got %b want %b", c, so1, c == 10); end
      nvec++; if (st1 !== ((c == 10) ? 3'd3 : 3'd2)) begin nbad++; $display("FAIL scan_state cyc %0d got %0d want %0d", c, st1, (c == 10) ? 3 : 2); end
      nvec++; if (hc1 !== seg_tbl[c]) begin nbad++; $display("FAIL scan_hex_count cyc %0d got %b want %b", c, hc1, seg_tbl[c]); end
    end
  endtask

  // Drain 10 -> 0, landing in LOW_POWER with count 0
  task automatic test_transfer();
    step();
    nvec++; if (st1 !== 3'd4 || c1 !== 4'd10) begin nbad++; $display("FAIL xfer_entry got st %0d cnt %0d want st 4 cnt 10", st1, c1); end
    for (int k = 9; k >= 0; k--) begin
      step();
      nvec++; if (c1 !== 4'(k)) begin nbad++; $display("FAIL xfer_count got %0d want %0d", c1, k); end
      nvec++; if (st1 !== ((k == 0) ? 3'd0 : 3'd4)) begin nbad++; $display("FAIL xfer_state cnt %0d got %0d want %0d", k, st1, (k == 0) ? 0 : 4); end
    end
    nvec++; if (hc1 !== 7'b1000000) begin nbad++; $display("FAIL xfer_hex_count got %b want 1000000", hc1); end
    step();
    nvec++; if (st1 !== 3'd0 || c1 !== 4'd0 || wo1 !== 1'b0 || so1 !== 1'b0) begin nbad++; $display("FAIL xfer_rest got st %0d cnt %0d", st1, c1); end
  endtask

  // Flush wins over xfer_ok; FLUSHING lasts one cycle
  task automatic test_flush();
    x1 = 1'b0; f1 = 1'b0; r1 = 1'b1;
    step();
    r1 = 1'b0;
    for (int c = 1; c <= 10; c++) step();
    step();
    nvec++; if (st1 !== 3'd3 || c1 !== 4'd10 || so1 !== 1'b0) begin nbad++; $display("FAIL idle_hold got st %0d cnt %0d so %b want 3 10 0", st1, c1, so1); end
    f1 = 1'b1; x1 = 1'b1;
    step();
    f1 = 1'b0; x1 = 1'b0;
    nvec++; if (st1 !== 3'd5) begin nbad++; $display("FAIL flush_state got %0d want 5", st1); end
    nvec++; if (hs1 !== 7'b0010010) begin nbad++; $display("FAIL flush_hex_state got %b want 0010010", hs1); end
    step();
    nvec++; if (st1 !== 3'd0 || c1 !== 4'd0) begin nbad++; $display("FAIL flush_exit got st %0d cnt %0d want 0 0", st1, c1); end
  endtask

  // Reset in the middle of a scan returns to SCANNING at 0
  task automatic test_reset_mid_scan();
    r1 = 1'b1; step(); r1 = 1'b0;
    for (int c = 1; c <= 5; c++) step();
    nvec++; if (c1 !== 4'd5) begin nbad++; $display("FAIL midscan_pre got %0d want 5", c1); end
    r1 = 1'b1; step(); r1 = 1'b0;
    nvec++; if (st1 !== 3'd2 || c1 !== 4'd0) begin nbad++; $display("FAIL midscan_reset got st %0d cnt %0d want 2 0", st1, c1); end
  endtask

  // start_in is ignored in LOW_POWER even alongside wake_in
  task automatic test_wake_start();
    si0 = 1'b1;
    step();
    nvec++; if (st0 !== 3'd0) begin nbad++; $display("FAIL lp_start_only got %0d want 0", st0); end
    wi0 = 1'b1; si0 = 1'b1;
    step();
    wi0 = 1'b0; si0 = 1'b0;
    nvec++; if (st0 !== 3'd1) begin nbad++; $display("FAIL lp_wake_start got %0d want 1", st0); end
    wi0 = 1'b1;
    step();
    wi0 = 1'b0;
    nvec++; if (st0 !== 3'd1) begin nbad++; $display("FAIL standby_wake got %0d want 1", st0); end
    si0 = 1'b1;
    step();
    si0 = 1'b0;
    nvec++; if (st0 !== 3'd2 || c0 !== 4'd0) begin nbad++; $display("FAIL standby_start got st %0d cnt %0d want 2 0", st0, c0); end
  endtask

  // Reset while draining at count 6
  task automatic test_reset_mid_xfer();
    x0 = 1'b1;
    for (int c = 1; c <= 15; c++) step();
    nvec++; if (st0 !== 3'd4 || c0 !== 4'd6) begin nbad++; $display("FAIL midxfer_pre got st %0d cnt %0d want 4 6", st0, c0); end
    r0 = 1'b1;
    step();
    r0 = 1'b0; x0 = 1'b0;
    nvec++; if (st0 !== 3'd0 || c0 !== 4'd0 || wo0 !== 1'b0 || so0 !== 1'b0) begin nbad++; $display("FAIL midxfer_reset got st %0d cnt %0d wo %b so %b want 0 0 0 0", st0, c0, wo0, so0); end
  endtask

  // Pair: handoff timing and mutual exclusion of SCANNING
  task automatic test_pair();
    rp = 1'b1; step(); rp = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      step();
      nvec++; if (sta === 3'd2 && stb === 3'd2) begin nbad++; $display("FAIL pair_both_scanning cyc %0d got a %0d b %0d", c, sta, stb); end
      if (c == 9 || c == 10) begin
        nvec++; if (stb !== 3'd1) begin nbad++; $display("FAIL pair_b_standby cyc %0d got %0d want 1", c, stb); end
      end
      if (c == 11) begin
        nvec++; if (stb !== 3'd2 || sta !== 3'd4) begin nbad++; $display("FAIL pair_handoff got a %0d b %0d want a 4 b 2", sta, stb); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_transfer();
    test_flush();
    test_reset_mid_scan();
    test_wake_start();
    test_reset_mid_xfer();
    test_pair();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
